// File: rtl/tri_bus_arbiter_if.sv
// tri_bus_arbiter_if
// Bundles the request side and the bus-driver side of the shared tri-state
// bus controller.
//   req      : per-requester level-sensitive bus request (N bits)
//   wdata    : flattened requester data, slice i is wdata[i*DW +: DW]
//   bus_en   : one-hot-or-zero enables for the tri-state buffers
//   bus_data : data for the buffers' a inputs
//   gnt      : grant back to the requesters (same as bus_en)
//   busy     : controller is owning the bus or in a turnaround cycle
// Modports:
//   master : requester side, drives req/wdata and observes the outputs
//   slave  : arbiter side, consumes req/wdata and drives the outputs
interface tri_bus_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    bus_en;
  logic [DW-1:0]   bus_data;
  logic [N-1:0]    gnt;
  logic            busy;

  modport master (
    output req, wdata,
    input  bus_en, bus_data, gnt, busy
  );

  modport slave (
    input  req, wdata,
    output bus_en, bus_data, gnt, busy
  );
endinterface

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter
// Round-robin arbiter and driver controller for a shared bus built from
// tri-state buffers. One requester at a time owns the bus; its data and the
// matching buffer enable are registered out. Ownership changes always pass
// through one all-zero turnaround cycle so two drivers never overlap, and an
// owner is forced off after MAX_HOLD cycles when someone else is waiting.
// Ports:
//   i_clk   : clock, all state changes on the rising edge
//   i_rst_n : synchronous active-low reset, priority over requests
//   bus     : tri_bus_arbiter_if.slave (req/wdata in; bus_en/bus_data/gnt/busy out)
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  tri_bus_arbiter_if.slave    bus
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [OW-1:0] LAST_RST = OW'(N - 1);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t          r_state, w_state_nxt;
  logic [OW-1:0]   r_owner, w_owner_nxt;
  logic [OW-1:0]   r_last, w_last_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
  logic [N-1:0]    r_bus_en, w_en_nxt;
  logic [DW-1:0]   r_bus_data, w_data_nxt;

  logic [OW-1:0]   w_pick;
  logic            w_pick_vld;
  logic [OW-1:0]   w_idx;
  logic [N-1:0]    w_owner_oh;
  logic            w_others;

  // Round-robin pick: scan from the farthest position back to last+1 so the
  // nearest set bit after the previous owner is the one that sticks.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_idx      = '0;
    for (int i = N; i >= 1; i--) begin
      w_idx = OW'((int'(r_last) + i) % N);
      if (bus.req[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_owner_oh = N'(1) << r_owner;
  assign w_others   = |(bus.req & ~w_owner_oh);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_en_nxt    = '0;
    w_data_nxt  = '0;

    case (r_state)
      // IDLE and TURN both grant the next pick; TURN additionally guarantees
      // the bus was floated for a cycle since the previous owner.
      IDLE, TURN: begin
        if (w_pick_vld) begin
          w_state_nxt = OWN;
          w_owner_nxt = w_pick;
          w_last_nxt  = w_pick;
          w_hold_nxt  = HW'(1);
        end else begin
          w_state_nxt = IDLE;
        end
      end
      OWN: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt = TURN;
        end else if (r_hold_cnt == HOLD_MAX && w_others) begin
          w_state_nxt = TURN;
        end else if (r_hold_cnt == HOLD_MAX) begin
          // Nobody else waiting: keep the bus without a turnaround.
          w_hold_nxt = HW'(1);
        end else begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are registered from the next state so enable and data line up
    // with the state they belong to.
    if (w_state_nxt == OWN) begin
      w_en_nxt   = N'(1) << w_owner_nxt;
      w_data_nxt = bus.wdata[w_owner_nxt*DW +: DW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= LAST_RST;
      r_hold_cnt <= '0;
      r_bus_en   <= '0;
      r_bus_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_bus_en   <= w_en_nxt;
      r_bus_data <= w_data_nxt;
    end
  end

  assign bus.bus_en   = r_bus_en;
  assign bus.gnt      = r_bus_en;
  assign bus.bus_data = r_bus_data;
  assign bus.busy     = (r_state != IDLE);

endmodule
